// File: rtl/mont_exp_ctrl_if.sv
// Start/done handshake between the exponentiation sequencer (master) and a
// Montgomery multiplier core (slave).
interface mont_exp_ctrl_if #(
    parameter int WIDTH = 512
);
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (output mm_start, mm_a, mm_b, mm_m, input  mm_result, mm_done);
    modport slave  (input  mm_start, mm_a, mm_b, mm_m, output mm_result, mm_done);
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer: scans every exponent bit, issues one
// Montgomery multiplication per step and finishes with a multiply by 1 to leave the domain.
module mont_exp_ctrl #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_xt,
    input  logic [WIDTH-1:0]     in_rm,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    mont_exp_ctrl_if.master      mm
);
    localparam int               IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SQ_ISSUE   = 4'd1;
    localparam logic [3:0] S_SQ_WAIT    = 4'd2;
    localparam logic [3:0] S_MUL_ISSUE  = 4'd3;
    localparam logic [3:0] S_MUL_WAIT   = 4'd4;
    localparam logic [3:0] S_NEXT       = 4'd5;
    localparam logic [3:0] S_POST_ISSUE = 4'd6;
    localparam logic [3:0] S_POST_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    logic [3:0]           state_q,    state_d;
    logic [WIDTH-1:0]     acc_q,      acc_d;
    logic [WIDTH-1:0]     xt_q,       xt_d;
    logic [WIDTH-1:0]     m_q,        m_d;
    logic [EXP_WIDTH-1:0] e_q,        e_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [WIDTH-1:0]     result_q,   result_d;
    logic [WIDTH-1:0]     mm_a_q,     mm_a_d;
    logic [WIDTH-1:0]     mm_b_q,     mm_b_d;
    logic                 mm_start_q, mm_start_d;
    logic                 mm_done_ok;

    // A completion can never coincide with our own start pulse, so treat that case as noise.
    assign mm_done_ok = mm.mm_done && !mm_start_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        xt_d       = xt_q;
        m_d        = m_q;
        e_d        = e_q;
        idx_d      = idx_q;
        result_d   = result_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xt_d    = in_xt;
                    m_d     = in_m;
                    e_d     = in_e;
                    acc_d   = in_rm;
                    idx_d   = IDX_TOP;
                    state_d = S_SQ_ISSUE;
                end
            end
            S_SQ_ISSUE: begin
                mm_a_d     = acc_q;
                mm_b_d     = acc_q;
                mm_start_d = 1'b1;
                state_d    = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm_done_ok) begin
                    acc_d   = mm.mm_result;
                    state_d = e_q[idx_q] ? S_MUL_ISSUE : S_NEXT;
                end
            end
            S_MUL_ISSUE: begin
                mm_a_d     = acc_q;
                mm_b_d     = xt_q;
                mm_start_d = 1'b1;
                state_d    = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mm_done_ok) begin
                    acc_d   = mm.mm_result;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_POST_ISSUE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_SQ_ISSUE;
                end
            end
            S_POST_ISSUE: begin
                // Multiplying by plain 1 strips the R factor, returning to the normal domain.
                mm_a_d     = acc_q;
                mm_b_d     = WIDTH'(1);
                mm_start_d = 1'b1;
                state_d    = S_POST_WAIT;
            end
            S_POST_WAIT: begin
                if (mm_done_ok) begin
                    result_d = mm.mm_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            xt_q       <= '0;
            m_q        <= '0;
            e_q        <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            xt_q       <= xt_d;
            m_q        <= m_d;
            e_q        <= e_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_start_q <= mm_start_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign mm.mm_start = mm_start_q;
    assign mm.mm_a     = mm_a_q;
    assign mm.mm_b     = mm_b_q;
    assign mm.mm_m     = m_q;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: a behavioural Montgomery core with programmable latency,
// and expected results from plain modular exponentiation.
module tb_mont_exp_ctrl;
    localparam int WIDTH       = 512;
    localparam int EXP_WIDTH   = 8;
    localparam int DONE_BUDGET = 2000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     in_xt;
    logic [WIDTH-1:0]     in_rm;
    logic [EXP_WIDTH-1:0] in_e;
    logic [WIDTH-1:0]     in_m;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;

    mont_exp_ctrl_if #(.WIDTH(WIDTH)) mm ();

    mont_exp_ctrl #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_xt  (in_xt),
        .in_rm  (in_rm),
        .in_e   (in_e),
        .in_m   (in_m),
        .busy   (busy),
        .done   (done),
        .result (result),
        .mm     (mm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Core-model configuration and observations
    int               lat_cfg = 5;   // 0 selects a random latency 1..20 per transaction
    int               pulse_cnt = 0;
    int               first_start_cyc = -1;
    int               last_done_cyc = -1;
    int               stab_err = 0;
    bit               stab_off = 1'b0;
    longint           core_m = 5;
    logic [WIDTH-1:0] m_exp = '0;
    int               start_cyc = 0;

    function automatic logic [WIDTH-1:0] wide(input longint v);
        return {{(WIDTH-64){1'b0}}, v};
    endfunction

    function automatic longint mod_pow(input longint base, input longint ex, input longint m);
        longint r = 1 % m;
        longint b = base % m;
        while (ex > 0) begin
            if (ex[0]) r = (r * b) % m;
            b  = (b * b) % m;
            ex = ex >> 1;
        end
        return r;
    endfunction

    // Montgomery product a*b*R^-1 mod m with R = 2^WIDTH; 2^-1 mod odd m is (m+1)/2.
    function automatic logic [WIDTH-1:0] mont_model(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input longint m);
        logic [WIDTH-1:0] mw;
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tb;
        longint ar, br, rinv;
        mw   = wide(m);
        ta   = a % mw;
        tb   = b % mw;
        ar   = longint'(ta[63:0]);
        br   = longint'(tb[63:0]);
        rinv = mod_pow((m + 1) / 2, WIDTH, m);
        return wide((((ar * br) % m) * rinv) % m);
    endfunction

    // Behavioural core: ignores reset so a late completion can be delivered on purpose.
    initial begin
        logic [WIDTH-1:0] a, b, r;
        int lat;
        mm.mm_done   = 1'b0;
        mm.mm_result = '0;
        forever begin
            @(posedge clk); #1;
            mm.mm_done = 1'b0;
            if (mm.mm_start === 1'b1) begin
                a = mm.mm_a;
                b = mm.mm_b;
                pulse_cnt++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
                lat = (lat_cfg == 0) ? int'($urandom_range(1, 20)) : lat_cfg;
                r = mont_model(a, b, core_m);
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (!stab_off && (mm.mm_a !== a || mm.mm_b !== b || mm.mm_m !== m_exp))
                        stab_err++;
                end
                mm.mm_done    = 1'b1;
                mm.mm_result  = r;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic launch(input longint x, input logic [EXP_WIDTH-1:0] e, input longint m);
        longint rm;
        rm = mod_pow(2, WIDTH, m);
        @(posedge clk); #1;
        in_xt  = wide(((x % m) * rm) % m);
        in_rm  = wide(rm);
        in_m   = wide(m);
        in_e   = e;
        core_m = m;
        m_exp  = wide(m);
        pulse_cnt       = 0;
        first_start_cyc = -1;
        stab_err        = 0;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int seen_cyc);
        seen     = 1'b0;
        seen_cyc = -1;
        for (int k = 0; k < DONE_BUDGET && !seen; k++) begin
            if (done === 1'b1) begin
                seen     = 1'b1;
                seen_cyc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mm.mm_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b mm_start=%b, required 0 0 0", busy, done, mm.mm_start);
        end
        checks++;
        if (result !== '0 || mm.mm_a !== '0 || mm.mm_b !== '0 || mm.mm_m !== '0) begin
            failures++;
            $display("FAIL reset_data: result=%0h mm_a=%0h mm_b=%0h mm_m=%0h, required all 0",
                     result, mm.mm_a, mm.mm_b, mm.mm_m);
        end
        reset = 1'b0;
    endtask

    task automatic test_patterns();
        logic [EXP_WIDTH-1:0] pats [3] = '{8'h00, 8'h02, 8'hFF};
        logic [WIDTH-1:0] exp_res;
        int exp_pulses;
        bit seen;
        int dcyc;
        lat_cfg = 5;
        foreach (pats[i]) begin
            launch(3, pats[i], 5);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_after_start e=%0h: busy=%b, required 1", pats[i], busy);
            end
            wait_done(seen, dcyc);
            exp_res    = wide(mod_pow(3, longint'(pats[i]), 5));
            exp_pulses = EXP_WIDTH + $countones(pats[i]) + 1;
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL done_timeout e=%0h: no done within %0d cycles", pats[i], DONE_BUDGET);
            end
            checks++;
            if (result !== exp_res) begin
                failures++;
                $display("FAIL result e=%0h: got %0h, required %0h", pats[i], result, exp_res);
            end
            checks++;
            if (pulse_cnt != exp_pulses) begin
                failures++;
                $display("FAIL pulse_count e=%0h: got %0d, required %0d", pats[i], pulse_cnt, exp_pulses);
            end
            checks++;
            if (first_start_cyc != start_cyc + 2) begin
                failures++;
                $display("FAIL first_issue_latency e=%0h: got %0d, required %0d",
                         pats[i], first_start_cyc - start_cyc, 2);
            end
            checks++;
            if (dcyc != last_done_cyc + 1) begin
                failures++;
                $display("FAIL done_latency e=%0h: got %0d, required 1", pats[i], dcyc - last_done_cyc);
            end
            checks++;
            if (stab_err != 0) begin
                failures++;
                $display("FAIL operand_stability e=%0h: %0d unstable cycles, required 0", pats[i], stab_err);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL done_one_cycle e=%0h: done=%b busy=%b, required 0 0", pats[i], done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        bit seen;
        int dcyc;
        logic [WIDTH-1:0] exp_res;
        lat_cfg = 5;
        launch(3, 8'h0B, 5);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        in_e  = 8'hFF;
        in_xt = wide(64'h1234_5678);
        in_rm = wide(64'h0BAD_F00D);
        in_m  = wide(7);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(seen, dcyc);
        exp_res = wide(mod_pow(3, 8'h0B, 5));
        checks++;
        if (!seen || result !== exp_res) begin
            failures++;
            $display("FAIL ignore_start_result: seen=%b got %0h, required %0h", seen, result, exp_res);
        end
        checks++;
        if (pulse_cnt != EXP_WIDTH + 3 + 1) begin
            failures++;
            $display("FAIL ignore_start_pulses: got %0d, required %0d", pulse_cnt, EXP_WIDTH + 4);
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL ignore_start_operands: %0d unstable cycles, required 0", stab_err);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int dcyc;
        int pulses_before;
        logic [WIDTH-1:0] prev;
        lat_cfg = 5;
        launch(3, 8'h03, 5);
        wait_done(seen, dcyc);
        prev = wide(mod_pow(3, 8'h03, 5));
        // A start presented during the DONE cycle must be dropped.
        start = 1'b1;
        pulses_before = pulse_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pulse_cnt != pulses_before) begin
            failures++;
            $display("FAIL start_in_done: busy=%b extra_pulses=%0d, required 0 0", busy, pulse_cnt - pulses_before);
        end
        launch(3, 8'h01, 5);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (result !== prev) begin
            failures++;
            $display("FAIL result_hold: got %0h, required %0h", result, prev);
        end
        wait_done(seen, dcyc);
        checks++;
        if (!seen || result !== wide(3)) begin
            failures++;
            $display("FAIL back_to_back_result: seen=%b got %0h, required 3", seen, result);
        end
    endtask

    task automatic test_random_latency();
        bit seen;
        int dcyc;
        longint m, x;
        logic [EXP_WIDTH-1:0] e;
        logic [WIDTH-1:0] exp_res;
        lat_cfg = 0;
        for (int n = 0; n < 5; n++) begin
            if (n == 0) begin
                m = 5; x = 3; e = 8'hA5;
            end else begin
                m = longint'($urandom_range(1, 32767)) * 2 + 1;
                x = longint'($urandom_range(0, 32'(m - 1)));
                e = EXP_WIDTH'($urandom);
            end
            launch(x, e, m);
            wait_done(seen, dcyc);
            exp_res = wide(mod_pow(x, longint'(e), m));
            checks++;
            if (!seen || result !== exp_res) begin
                failures++;
                $display("FAIL rand_result x=%0d e=%0h m=%0d: seen=%b got %0h, required %0h",
                         x, e, m, seen, result, exp_res);
            end
            checks++;
            if (pulse_cnt != EXP_WIDTH + $countones(e) + 1 || stab_err != 0) begin
                failures++;
                $display("FAIL rand_handshake e=%0h: pulses=%0d unstable=%0d, required %0d 0",
                         e, pulse_cnt, stab_err, EXP_WIDTH + $countones(e) + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dcyc;
        int bad;
        int pulses_before;
        lat_cfg = 10;
        launch(3, 8'h5A, 5);
        for (int k = 0; k < 20 && pulse_cnt < 1; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pulse_cnt < 1) begin
            failures++;
            $display("FAIL reset_mid_issue: no mm_start within 20 cycles, required one");
        end
        stab_off = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || result !== '0 || mm.mm_a !== '0 || mm.mm_b !== '0 || mm.mm_m !== '0) begin
            failures++;
            $display("FAIL reset_mid_values: busy=%b result=%0h mm_a=%0h mm_b=%0h mm_m=%0h, required all 0",
                     busy, result, mm.mm_a, mm.mm_b, mm.mm_m);
        end
        bad = 0;
        pulses_before = pulse_cnt;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0 || mm.mm_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || pulse_cnt != pulses_before) begin
            failures++;
            $display("FAIL late_done_ignored: %0d active cycles, %0d extra pulses, required 0 0",
                     bad, pulse_cnt - pulses_before);
        end
        stab_off = 1'b0;
        launch(3, 8'h01, 5);
        wait_done(seen, dcyc);
        checks++;
        if (!seen || result !== wide(3) || pulse_cnt != EXP_WIDTH + 2) begin
            failures++;
            $display("FAIL after_reset_result: seen=%b got %0h pulses=%0d, required 3 %0d",
                     seen, result, pulse_cnt, EXP_WIDTH + 2);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_xt = '0;
        in_rm = '0;
        in_e  = '0;
        in_m  = '0;
        test_reset();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_random_latency();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
